cx_req_arbiter: RTL
===================

CX_REQ_ARBITER -- requirements
Module: cx_req_arbiter

Interface
REQ-001 Parameter: N_REQ, 2, number of requesters sharing the single CX switch port (2..4).
REQ-002 Parameter: TIMEOUT, 255, watchdog limit in cycles (used only with CX_ARB_TIMEOUT_EN).
REQ-003 clk  in  1  sole clock.
REQ-004 rst  in  1  asynchronous reset, active-low.
REQ-005 req_valid  in  N_REQ  per-requester request valid.
REQ-006 req_ready  out  N_REQ  per-requester request accept.
REQ-007 req_cxu_id  in  2*N_REQ  target CXU per requester (slice i = bits 2i+1:2i).
REQ-008 req_state_id  in  2*N_REQ  state id per requester.
REQ-009 req_data0, req_data1  in  32*N_REQ  operands per requester.
REQ-010 resp_valid  out  N_REQ  response valid to the granted requester.
REQ-011 resp_ready  in  N_REQ  requester response accept.
REQ-012 resp_data  out  32  response data (shared, qualified by resp_valid).
REQ-013 resp_status  out  4  response status (shared).
REQ-014 cx_req_valid, cx_req_ready  out/in  1  request handshake to switch.
REQ-015 cx_cxu_id, cx_state_id  out  2 each  forwarded request fields.
REQ-016 cx_req_data0, cx_req_data1  out  32 each  forwarded operands.
REQ-017 cx_resp_valid, cx_resp_ready  in/out  1  response handshake from switch.
REQ-018 cx_resp_data  in  32; cx_resp_status  in  4  switch response.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_RESP, DELIVER; exactly one transaction outstanding.
REQ-021 IDLE: round-robin pick among req_valid starting at rr_ptr; winner gets req_ready=1 same cycle, fields latched, grant_q=winner, rr_ptr<=winner+1 mod N_REQ, next state ISSUE.
REQ-022 req_ready SHALL be 0 for all requesters outside IDLE and for non-winners.
REQ-023 ISSUE: cx_req_valid=1 with latched fields stable; on cx_req_ready go WAIT_RESP.
REQ-024 WAIT_RESP: cx_resp_ready=1; on cx_resp_valid latch data/status, go DELIVER.
REQ-025 DELIVER: resp_valid[grant_q]=1 with latched data/status; on resp_ready[grant_q] go IDLE.
REQ-026 Minimum latency: accept cycle 0, cx_req_valid cycle 1, response to requester one cycle after cx_resp_valid.
REQ-027 Requester i deasserting req_valid before acceptance SHALL NOT be granted; a requester may re-request in the cycle after DELIVER completes.
REQ-028 resp_data/resp_status SHALL be 0 outside DELIVER; cx_req_* fields SHALL be 0 outside ISSUE.

Reset
REQ-029 On rst low: state IDLE, rr_ptr=0, all latches 0, all valid/ready outputs 0, busy 0; mid-transaction reset drops the transaction silently.

Configuration
REQ-030 With CX_ARB_TIMEOUT_EN defined: counter clears on entry to ISSUE, increments in ISSUE/WAIT_RESP; on reaching TIMEOUT, go DELIVER with data 0, status 4'hF (cx_req_valid dropped).
REQ-031 If cx_resp_valid arrives in the timeout cycle, the real response SHALL win.
REQ-032 Without CX_ARB_TIMEOUT_EN: no counter, FSM waits indefinitely; TIMEOUT unused.

Structure
REQ-033 Package cx_arb_pkg SHALL hold the state enum and STATUS_TIMEOUT = 4'hF.
REQ-034 Round-robin pick SHALL be sub-module cx_rr_pick (combinational: valid vector, pointer -> one-hot grant, index).

Verification
REQ-035 Single request: req 0, cxu_id=2, data0=0x11, switch resp 0xCAFE status 0 -> resp_valid[0], data 0xCAFE, status 0.
REQ-036 Contention: req 0 and 1 valid continuously -> grants alternate 0,1,0,1 across four transactions.
REQ-037 Backpressure: cx_req_ready low 5 cycles, resp_ready low 3 cycles -> fields/data held stable, no second accept.
REQ-038 Timeout (macro on, TIMEOUT=8): switch never responds -> resp status 4'hF, data 0 after 8 cycles; simultaneous response at cycle 8 -> real data.
REQ-039 Reset in WAIT_RESP -> all outputs 0 next edge, rr_ptr=0, next grant to requester 0.

Source files
------------

// File: rtl/cx_arb_pkg.sv
// Shared types and constants for the CX request arbiter.
// Holds the arbiter FSM state enum and the timeout status code.
package cx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RESP,
      DELIVER
   } arb_state_e;

   localparam int DATA_W = 32;
   localparam int ID_W   = 2;
   localparam int STAT_W = 4;

   localparam logic [STAT_W-1:0] STATUS_TIMEOUT = 4'hF;

endpackage

// File: rtl/cx_req_arbiter_if.sv
// Requester-side and switch-side handshake bundles of the CX arbiter.
// master drives the request, slave accepts it and returns the response.
interface cx_arb_req_if
   import cx_arb_pkg::*;
#(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [ID_W*N_REQ-1:0]   req_cxu_id;
   logic [ID_W*N_REQ-1:0]   req_state_id;
   logic [DATA_W*N_REQ-1:0] req_data0;
   logic [DATA_W*N_REQ-1:0] req_data1;
   logic [N_REQ-1:0]        resp_valid;
   logic [N_REQ-1:0]        resp_ready;
   logic [DATA_W-1:0]       resp_data;
   logic [STAT_W-1:0]       resp_status;

   modport master (
      output req_valid, req_cxu_id, req_state_id,
      output req_data0, req_data1, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_status
   );

   modport slave (
      input  req_valid, req_cxu_id, req_state_id,
      input  req_data0, req_data1, resp_ready,
      output req_ready, resp_valid, resp_data, resp_status
   );
endinterface

interface cx_arb_sw_if
   import cx_arb_pkg::*;
;
   logic              cx_req_valid;
   logic              cx_req_ready;
   logic [ID_W-1:0]   cx_cxu_id;
   logic [ID_W-1:0]   cx_state_id;
   logic [DATA_W-1:0] cx_req_data0;
   logic [DATA_W-1:0] cx_req_data1;
   logic              cx_resp_valid;
   logic              cx_resp_ready;
   logic [DATA_W-1:0] cx_resp_data;
   logic [STAT_W-1:0] cx_resp_status;

   modport master (
      output cx_req_valid, cx_cxu_id, cx_state_id,
      output cx_req_data0, cx_req_data1, cx_resp_ready,
      input  cx_req_ready, cx_resp_valid,
      input  cx_resp_data, cx_resp_status
   );

   modport slave (
      input  cx_req_valid, cx_cxu_id, cx_state_id,
      input  cx_req_data0, cx_req_data1, cx_resp_ready,
      output cx_req_ready, cx_resp_valid,
      output cx_resp_data, cx_resp_status
   );
endinterface

// File: rtl/cx_rr_pick.sv
// Combinational round-robin picker: first valid at or after ptr.
// Returns a one-hot grant, its index and an any-valid flag.
module cx_rr_pick
   import cx_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int IW    = 1
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic [IW-1:0] j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = IW'((int'(ptr) + k) % N_REQ);
         if (!any && valid[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end

endmodule

// File: rtl/cx_req_arbiter.sv
// Round-robin arbiter sharing one CX switch port among N_REQ requesters.
// Define CX_ARB_TIMEOUT_EN to enable the TIMEOUT-cycle response watchdog.
module cx_req_arbiter
   import cx_arb_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic         clk,
   input  logic         rst,
   cx_arb_req_if.slave  req,
   cx_arb_sw_if.master  cx,
   output logic         busy
);

   localparam int IW = $clog2(N_REQ);

   arb_state_e state_q, state_d;

   logic [IW-1:0]     rr_ptr_q;
   logic [IW-1:0]     grant_q;
   logic [IW-1:0]     win_idx;
   logic [N_REQ-1:0]  win_oh;
   logic              win_any;
   logic [ID_W-1:0]   cxu_q, sid_q;
   logic [DATA_W-1:0] d0_q, d1_q, rdata_q;
   logic [STAT_W-1:0] rstat_q;
   logic [ID_W-1:0]   sel_cxu, sel_sid;
   logic [DATA_W-1:0] sel_d0, sel_d1;
   logic              accept, cx_fire, resp_fire, tmo;

   cx_rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_pick (
      .valid (req.req_valid),
      .ptr   (rr_ptr_q),
      .grant (win_oh),
      .idx   (win_idx),
      .any   (win_any)
   );

   // rst gates the grant so no requester sees ready while held in reset
   assign accept    = rst && (state_q == IDLE) && win_any;
   assign cx_fire   = (state_q == ISSUE) && cx.cx_req_ready;
   assign resp_fire = (state_q == WAIT_RESP) && cx.cx_resp_valid;

`ifdef CX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic          in_flight;

   assign in_flight = (state_q == ISSUE) || (state_q == WAIT_RESP);
   assign tmo       = in_flight && (cnt_q >= CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= '0;
      end else if (in_flight && (cnt_q < CW'(TIMEOUT))) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = TIMEOUT;
   assign tmo            = 1'b0;
`endif

   always_comb begin
      sel_cxu = '0;
      sel_sid = '0;
      sel_d0  = '0;
      sel_d1  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_cxu |= {ID_W{win_oh[i]}}
                  & req.req_cxu_id[i*ID_W +: ID_W];
         sel_sid |= {ID_W{win_oh[i]}}
                  & req.req_state_id[i*ID_W +: ID_W];
         sel_d0  |= {DATA_W{win_oh[i]}}
                  & req.req_data0[i*DATA_W +: DATA_W];
         sel_d1  |= {DATA_W{win_oh[i]}}
                  & req.req_data1[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = ISSUE;
         end
         ISSUE: begin
            if (cx.cx_req_ready) state_d = WAIT_RESP;
            else if (tmo)        state_d = DELIVER;
         end
         WAIT_RESP: begin
            if (cx.cx_resp_valid || tmo) state_d = DELIVER;
         end
         DELIVER: begin
            if (req.resp_ready[grant_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         cxu_q    <= '0;
         sid_q    <= '0;
         d0_q     <= '0;
         d1_q     <= '0;
         rdata_q  <= '0;
         rstat_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            grant_q  <= win_idx;
            rr_ptr_q <= (win_idx == IW'(N_REQ - 1))
                      ? '0 : win_idx + 1'b1;
            cxu_q    <= sel_cxu;
            sid_q    <= sel_sid;
            d0_q     <= sel_d0;
            d1_q     <= sel_d1;
         end
         // a real response in the watchdog cycle beats the timeout
         if (resp_fire) begin
            rdata_q <= cx.cx_resp_data;
            rstat_q <= cx.cx_resp_status;
         end else if (tmo && !cx_fire) begin
            rdata_q <= '0;
            rstat_q <= STATUS_TIMEOUT;
         end
      end
   end

   assign req.req_ready   = accept ? win_oh : '0;
   assign req.resp_valid  = (state_q == DELIVER)
                          ? (N_REQ'(1) << grant_q) : '0;
   assign req.resp_data   = (state_q == DELIVER) ? rdata_q : '0;
   assign req.resp_status = (state_q == DELIVER) ? rstat_q : '0;

   assign cx.cx_req_valid  = (state_q == ISSUE);
   assign cx.cx_cxu_id     = (state_q == ISSUE) ? cxu_q : '0;
   assign cx.cx_state_id   = (state_q == ISSUE) ? sid_q : '0;
   assign cx.cx_req_data0  = (state_q == ISSUE) ? d0_q : '0;
   assign cx.cx_req_data1  = (state_q == ISSUE) ? d1_q : '0;
   assign cx.cx_resp_ready = (state_q == WAIT_RESP);

   assign busy = (state_q != IDLE);

endmodule
